// File: rtl/calc_pkg.sv
// calc_pkg: shared FSM encoding, key ASCII codes and keypad map for the calculator controller.
// The MUL state only exists when CALC_MUL_EN is defined.
package calc_pkg;
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      GOT_A  = 3'd1,
      GOT_OP = 3'd2,
      GOT_B  = 3'd3,
      DONE   = 3'd4
`ifdef CALC_MUL_EN
      , MUL  = 3'd5
`endif
   } state_e;

   localparam logic [15:0] SAT_MAX  = 16'hFFFF;
   localparam logic [7:0]  CH_0     = 8'h30;
   localparam logic [7:0]  CH_9     = 8'h39;
   localparam logic [7:0]  CH_PLUS  = 8'h2B;
   localparam logic [7:0]  CH_MINUS = 8'h2D;
   localparam logic [7:0]  CH_MUL   = 8'h2A;
   localparam logic [7:0]  CH_EQ    = 8'h3D;
   localparam logic [7:0]  CH_C     = 8'h43;
   localparam logic [7:0]  CH_BLANK = 8'h20;

   // indexed by {row, col}
   localparam logic [7:0] KEY_MAP [16] = '{
      8'h31, 8'h32, 8'h33, CH_PLUS,
      8'h34, 8'h35, 8'h36, CH_MINUS,
      8'h37, 8'h38, 8'h39, CH_MUL,
      CH_C,  CH_0,  CH_EQ, CH_BLANK
   };

   function automatic logic is_digit(input logic [7:0] k);
      return k >= CH_0 && k <= CH_9;
   endfunction

   function automatic logic is_op(input logic [7:0] k);
      return k == CH_PLUS || k == CH_MINUS || k == CH_MUL;
   endfunction
endpackage

// File: rtl/calc_mul.sv
// calc_mul: 4-cycle shift-add multiplier (16x4), one bit of b per cycle, LSB first.
// done/product/saturated are valid combinationally in the final run cycle.
module calc_mul
   import calc_pkg::*;
(
   input  logic        clk_in,
   input  logic        sys_rst,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] a,
   input  logic [3:0]  b,
   output logic        done,
   output logic [15:0] product,
   output logic        saturated
);
   logic [15:0] a_q;
   logic [3:0]  b_q;
   logic [19:0] acc_q, acc_d;
   logic [1:0]  cnt_q;
   logic        run_q;

   always_ff @(posedge clk_in) begin
      if (sys_rst || abort) begin
         run_q <= 1'b0;
         cnt_q <= '0;
         acc_q <= '0;
      end else if (start) begin
         run_q <= 1'b1;
         cnt_q <= '0;
         acc_q <= '0;
         a_q   <= a;
         b_q   <= b;
      end else if (run_q) begin
         acc_q <= acc_d;
         cnt_q <= cnt_q + 2'd1;
         run_q <= cnt_q != 2'd3;
      end
   end

   assign acc_d     = acc_q + (b_q[cnt_q] ? {4'b0, a_q} << cnt_q : 20'd0);
   assign done      = run_q && cnt_q == 2'd3;
   assign saturated = |acc_d[19:16];
   assign product   = acc_d[15:0];
endmodule

// File: rtl/calc_ctrl.sv
// calc_ctrl: 4x4 keypad calculator controller (cursor, operand entry, + - and optional *).
// Define CALC_MUL_EN to enable the "*" key and the shift-add multiplier.
module calc_ctrl
   import calc_pkg::*;
(
   input  logic        clk_in,
   input  logic        sys_rst,
   input  logic        key_up,
   input  logic        key_down,
   input  logic        key_left,
   input  logic        key_right,
   input  logic        key_sel,
   output logic [3:0]  cursor_x,
   output logic [3:0]  cursor_y,
   output logic [7:0]  input_val,
   output logic [7:0]  op_char,
   output logic [15:0] result,
   output logic        calc_done,
   output logic        busy
);
   state_e      state_q, state_d;
   logic [1:0]  x_q, x_d, y_q, y_d;
   logic [15:0] a_q, a_d, res_q, res_d;
   logic [3:0]  b_q, b_d, d;
   logic [7:0]  iv_q, iv_d, op_q, op_d, key, k;
   logic        done_q, done_d, dig, op, eq, clr;
   logic [16:0] sum;
   logic [15:0] add_sat, sub_clamp;

   assign key = KEY_MAP[{y_q, x_q}];
`ifdef CALC_MUL_EN
   assign k = key_sel ? key : CH_BLANK;
`else
   assign k = key_sel && key != CH_MUL ? key : CH_BLANK;
`endif
   assign d   = k[3:0];
   assign dig = is_digit(k);
   assign op  = is_op(k);
   assign eq  = k == CH_EQ;
   assign clr = k == CH_C;

   // opposing pulses cancel; 2-bit wrap gives 3->0 and 0->3
   assign x_d = x_q + {1'b0, key_right & ~key_left} - {1'b0, key_left & ~key_right};
   assign y_d = y_q + {1'b0, key_down & ~key_up} - {1'b0, key_up & ~key_down};

   assign sum       = {1'b0, a_q} + {13'b0, b_q};
   assign add_sat   = sum[16] ? SAT_MAX : sum[15:0];
   assign sub_clamp = a_q < {12'b0, b_q} ? 16'd0 : a_q - {12'b0, b_q};

`ifdef CALC_MUL_EN
   logic        mul_start, mul_done, mul_sat;
   logic [15:0] mul_prod;

   calc_mul u_mul (
      .clk_in    (clk_in),
      .sys_rst   (sys_rst),
      .start     (mul_start),
      .abort     (clr),
      .a         (a_q),
      .b         (b_q),
      .done      (mul_done),
      .product   (mul_prod),
      .saturated (mul_sat)
   );
   assign busy = state_q == MUL;
`else
   assign busy = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      iv_d    = iv_q;
      op_d    = op_q;
      res_d   = res_q;
      done_d  = done_q;
`ifdef CALC_MUL_EN
      mul_start = 1'b0;
`endif
      if (clr) begin
         state_d = IDLE;
         a_d     = '0;
         b_d     = '0;
         iv_d    = '0;
         op_d    = '0;
         done_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE:
               if (dig) begin
                  a_d     = {12'b0, d};
                  iv_d    = k;
                  state_d = GOT_A;
               end
            GOT_A:
               if (dig) begin
                  a_d  = {12'b0, d};
                  iv_d = k;
               end else if (op) begin
                  op_d    = k;
                  state_d = GOT_OP;
               end
            GOT_OP:
               if (dig) begin
                  b_d     = d;
                  iv_d    = k;
                  state_d = GOT_B;
               end else if (op) op_d = k;
            GOT_B:
               if (dig) begin
                  b_d  = d;
                  iv_d = k;
               end else if (eq) begin
`ifdef CALC_MUL_EN
                  if (op_q == CH_MUL) begin
                     mul_start = 1'b1;
                     state_d   = MUL;
                  end else
`endif
                  begin
                     res_d   = op_q == CH_PLUS ? add_sat : sub_clamp;
                     done_d  = 1'b1;
                     state_d = DONE;
                  end
               end
`ifdef CALC_MUL_EN
            MUL:
               if (mul_done) begin
                  res_d   = mul_sat ? SAT_MAX : mul_prod;
                  done_d  = 1'b1;
                  state_d = DONE;
               end
`endif
            DONE:
               if (dig) begin
                  a_d     = {12'b0, d};
                  iv_d    = k;
                  op_d    = '0;
                  done_d  = 1'b0;
                  state_d = GOT_A;
               end else if (op) begin
                  a_d     = res_q;
                  op_d    = k;
                  done_d  = 1'b0;
                  state_d = GOT_OP;
               end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (sys_rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         iv_q    <= '0;
         op_q    <= '0;
         res_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         a_q     <= a_d;
         b_q     <= b_d;
         iv_q    <= iv_d;
         op_q    <= op_d;
         res_q   <= res_d;
         done_q  <= done_d;
      end
   end

   assign cursor_x  = {2'b0, x_q};
   assign cursor_y  = {2'b0, y_q};
   assign input_val = iv_q;
   assign op_char   = op_q;
   assign result    = res_q;
   assign calc_done = done_q;
endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl: directed + random stimulus against a behavioural calculator model.
// Honours CALC_MUL_EN the same way as the design.
module tb_calc_ctrl;
   logic        clk_in = 1'b0;
   logic        sys_rst = 1'b0, key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0, key_sel = 1'b0;
   logic [3:0]  cursor_x, cursor_y;
   logic [7:0]  input_val, op_char;
   logic [15:0] result;
   logic        calc_done, busy;

   always #5 clk_in = ~clk_in;

   calc_ctrl dut (
      .clk_in    (clk_in),
      .sys_rst   (sys_rst),
      .key_up    (key_up),
      .key_down  (key_down),
      .key_left  (key_left),
      .key_right (key_right),
      .key_sel   (key_sel),
      .cursor_x  (cursor_x),
      .cursor_y  (cursor_y),
      .input_val (input_val),
      .op_char   (op_char),
      .result    (result),
      .calc_done (calc_done),
      .busy      (busy)
   );

   localparam int P_IDLE = 0, P_A = 1, P_OP = 2, P_B = 3, P_MUL = 4, P_DONE = 5;
   string grid = "123+456-789*C0= ";
   int total = 0, bad = 0;
   int mx = 0, my = 0, ma = 0, mb = 0, mph = P_IDLE, mcnt = 0, m_iv = 0, m_op = 0, m_res = 0, m_done = 0, m_pend = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk_in) if (chk_en) begin
      check("cursor_x", cursor_x, mx);
      check("cursor_y", cursor_y, my);
      check("input_val", input_val, m_iv);
      check("op_char", op_char, m_op);
      check("result", result, m_res);
      check("calc_done", calc_done, m_done);
      check("busy", busy, mph == P_MUL);
   end

   function automatic int sat(input int v);
      return v > 65535 ? 65535 : v;
   endfunction

   // one clock of stimulus; the model advances to what the outputs must show after this edge
   task automatic step(input bit r, input bit u, input bit dn, input bit l, input bit rt, input bit s);
      byte k;
      @(negedge clk_in);
      #1;
      sys_rst = r; key_up = u; key_down = dn; key_left = l; key_right = rt; key_sel = s;
      if (r) begin
         mx = 0; my = 0; ma = 0; mb = 0; mph = P_IDLE; mcnt = 0;
         m_iv = 0; m_op = 0; m_res = 0; m_done = 0;
         chk_en = 1'b1;
         return;
      end
      k = s ? grid[my * 4 + mx] : " ";
`ifndef CALC_MUL_EN
      if (k == "*") k = " ";
`endif
      mx = (mx + int'(rt && !l) - int'(l && !rt) + 4) % 4;
      my = (my + int'(dn && !u) - int'(u && !dn) + 4) % 4;
      if (k == "C") begin
         ma = 0; mb = 0; m_iv = 0; m_op = 0; m_done = 0; mph = P_IDLE; mcnt = 0;
      end else if (mph == P_MUL) begin
         mcnt--;
         if (mcnt == 0) begin
            m_res = m_pend; m_done = 1; mph = P_DONE;
         end
      end else if (k >= "0" && k <= "9") begin
         m_iv = k;
         case (mph)
            P_IDLE, P_A: begin ma = k - "0"; mph = P_A; end
            P_OP, P_B:   begin mb = k - "0"; mph = P_B; end
            P_DONE:      begin ma = k - "0"; m_op = 0; m_done = 0; mph = P_A; end
            default: ;
         endcase
      end else if (k == "+" || k == "-" || k == "*") begin
         if (mph == P_A || mph == P_OP) begin
            m_op = k; mph = P_OP;
         end else if (mph == P_DONE) begin
            ma = m_res; m_op = k; m_done = 0; mph = P_OP;
         end
      end else if (k == "=" && mph == P_B) begin
         if (m_op == "*") begin
            m_pend = sat(ma * mb); mcnt = 4; mph = P_MUL;
         end else begin
            m_res = m_op == "+" ? sat(ma + mb) : (ma < mb ? 0 : ma - mb);
            m_done = 1; mph = P_DONE;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic goto_key(input byte ch);
      int tx = 0, ty = 0;
      for (int i = 0; i < 16; i++) if (grid[i] == ch) begin tx = i % 4; ty = i / 4; end
      while (mx != tx || my != ty) step(0, 0, my != ty, 0, mx != tx, 0);
   endtask

   task automatic press(input byte ch);
      goto_key(ch);
      step(0, 0, 0, 0, 0, 1);
   endtask

   // let the last stepped inputs be clocked in before a literal check
   task automatic sync();
      @(posedge clk_in);
      #1;
   endtask

   initial begin
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 1);
      sync();
      check("rst_result", result, 0);
      check("rst_cursor", {cursor_y, cursor_x}, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
      sync();
      check("wrap_x", cursor_x, 0);
      step(0, 1, 0, 0, 0, 0);
      sync();
      check("wrap_y", cursor_y, 3);

      press("7"); press("+"); press("8"); press("=");
      sync();
      check("add_done", calc_done, 1);
      check("add_res", result, 15);
      check("add_iv", input_val, "8");
      check("add_op", op_char, "+");

      press("3"); press("-"); press("9"); press("=");
      sync();
      check("sub_clamp", result, 0);
      press("+"); press("5"); press("=");
      sync();
      check("chain_add", result, 5);

`ifdef CALC_MUL_EN
      press("9"); press("*"); press("9"); press("=");
      for (int i = 0; i < 4; i++) begin
         sync();
         check("mul_busy", busy, 1);
         step(0, 0, 0, 0, 0, 0);
      end
      sync();
      check("mul_busy_end", busy, 0);
      check("mul_done", calc_done, 1);
      check("mul_res", result, 81);
      press("*"); press("9"); press("=");
      press("C");
      sync();
      check("abort_busy", busy, 0);
      check("abort_hold", result, 81);
      check("abort_done", calc_done, 0);
      press("9"); press("*"); press("9"); press("=");
      idle(5);
      for (int i = 0; i < 5; i++) begin
         press("*"); press("9"); press("=");
         idle(5);
      end
      check("mul_sat", result, 65535);
`else
      press("7"); press("+"); press("*");
      sync();
      check("star_ignored", op_char, "+");
`endif

      press("C");
      goto_key("1");
      step(0, 0, 0, 0, 1, 1);
      sync();
      check("sel_move_iv", input_val, "1");
      check("sel_move_x", cursor_x, 1);

      for (int i = 0; i < 3000; i++)
         step($urandom_range(299) == 0, $urandom_range(4) == 0, $urandom_range(4) == 0,
              $urandom_range(4) == 0, $urandom_range(4) == 0, $urandom_range(2) == 0);
      idle(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
